// File: rtl/machine_mode_types_1_12_pkg.sv
// Shared types and constants for the v1.12 machine-mode trap sequencer.
package machine_mode_types_1_12_pkg;

    // Kind of control transfer being sequenced
    typedef enum logic [1:0] {
        KIND_EXC = 2'd0,
        KIND_INT = 2'd1,
        KIND_RET = 2'd2
    } trap_kind_e;

    // Trap sequencer FSM states
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DRAIN    = 2'd1,
        ST_COMMIT   = 2'd2,
        ST_REDIRECT = 2'd3
    } trap_state_e;

    // Privilege levels
    localparam logic [1:0] PRIV_U = 2'b00;
    localparam logic [1:0] PRIV_M = 2'b11;

    // mtvec modes (10/11 are reserved and behave as direct)
    localparam logic [1:0] MTVEC_DIRECT   = 2'b00;
    localparam logic [1:0] MTVEC_VECTORED = 2'b01;

    // Trap vector: only interrupts in vectored mode are offset by 4*cause
    function automatic logic [31:0] trap_target(
        input logic [29:0] base,
        input logic [1:0]  mode,
        input logic        is_int,
        input logic [4:0]  code
    );
        logic [31:0] w_base;
        w_base = {base, 2'b00};
        if (is_int && (mode == MTVEC_VECTORED)) begin
            return w_base + {25'd0, code, 2'b00};
        end
        return w_base;
    endfunction

endpackage

// File: rtl/priv_1_12_drain_watchdog.sv
// Drain watchdog: saturating cycle counter with clear/enable and a sticky
// expire flag raised once the count reaches its all-ones value.
module priv_1_12_drain_watchdog #(
    parameter int TIMEOUT_W = 8
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    localparam logic [TIMEOUT_W-1:0] MAX_CNT = '1;

    logic [TIMEOUT_W-1:0] r_count;
    logic                 r_expired;

    function automatic logic [TIMEOUT_W-1:0] sat_inc(input logic [TIMEOUT_W-1:0] v);
        return (v == MAX_CNT) ? v : v + 1'b1;
    endfunction

    // Count enabled cycles, clear on request, latch expiry until reset
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count   <= '0;
            r_expired <= 1'b0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= sat_inc(r_count);
            if (sat_inc(r_count) == MAX_CNT) begin
                r_expired <= 1'b1;
            end
        end
    end

    assign o_expired = r_expired;

endmodule

// File: rtl/priv_1_12_trap_seq.sv
// Trap-entry / MRET sequencer: latch request, wait for pipeline drain,
// commit machine-mode CSR updates in one cycle, then redirect the PC.
module priv_1_12_trap_seq
    import machine_mode_types_1_12_pkg::*;
#(
    parameter int TIMEOUT_W = 8,
    parameter bit HAS_U     = 1'b1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        exc_req,
    input  logic [4:0]  exc_code,
    input  logic [31:0] exc_tval,
    input  logic        int_req,
    input  logic [4:0]  int_code,
    input  logic        mret_req,
    input  logic [31:0] epc,
    input  logic        pipe_clear,
    input  logic [29:0] mtvec_base,
    input  logic [1:0]  mtvec_mode,
    input  logic [31:0] mepc_in,
    input  logic        mstatus_mie,
    input  logic        mstatus_mpie,
    input  logic [1:0]  mstatus_mpp,
    output logic        inject_mcause,
    output logic        inject_mepc,
    output logic        inject_mtval,
    output logic        inject_mstatus,
    output logic [31:0] next_mcause,
    output logic [31:0] next_mepc,
    output logic [31:0] next_mtval,
    output logic        next_mie,
    output logic        next_mpie,
    output logic [1:0]  next_mpp,
    output logic        insert_pc,
    output logic [31:0] priv_pc,
    output logic [1:0]  curr_priv,
    output logic        busy,
    output logic        hang_err
);

    trap_state_e r_state;
    trap_kind_e  r_kind;
    logic [4:0]  r_code;
    logic [31:0] r_epc;
    logic [31:0] r_tval;

    logic        r_inj_trap;
    logic        r_inj_mstatus;
    logic [31:0] r_next_mcause;
    logic [31:0] r_next_mepc;
    logic [31:0] r_next_mtval;
    logic        r_next_mie;
    logic        r_next_mpie;
    logic [1:0]  r_next_mpp;
    logic        r_insert_pc;
    logic [31:0] r_priv_pc;
    logic [1:0]  r_curr_priv;

    logic        w_take;
    logic        w_drain;
    logic        w_hang;

    assign w_take  = (r_state == ST_IDLE) && (exc_req || mret_req || int_req);
    assign w_drain = (r_state == ST_DRAIN);

    priv_1_12_drain_watchdog #(
        .TIMEOUT_W (TIMEOUT_W)
    ) u_watchdog (
        .i_clk     (CLK),
        .i_rst     (RST),
        .i_clr     (w_take),
        .i_en      (w_drain),
        .o_expired (w_hang)
    );

    // Sequencer FSM with all CSR/redirect outputs registered
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state       <= ST_IDLE;
            r_kind        <= KIND_EXC;
            r_code        <= '0;
            r_epc         <= '0;
            r_tval        <= '0;
            r_inj_trap    <= 1'b0;
            r_inj_mstatus <= 1'b0;
            r_next_mcause <= '0;
            r_next_mepc   <= '0;
            r_next_mtval  <= '0;
            r_next_mie    <= 1'b0;
            r_next_mpie   <= 1'b0;
            r_next_mpp    <= '0;
            r_insert_pc   <= 1'b0;
            r_priv_pc     <= '0;
            r_curr_priv   <= PRIV_M;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_insert_pc <= 1'b0;
                    if (exc_req) begin
                        r_kind  <= KIND_EXC;
                        r_code  <= exc_code;
                        r_tval  <= exc_tval;
                        r_epc   <= epc;
                        r_state <= ST_DRAIN;
                    end else if (mret_req) begin
                        r_kind  <= KIND_RET;
                        r_code  <= '0;
                        r_tval  <= '0;
                        r_epc   <= epc;
                        r_state <= ST_DRAIN;
                    end else if (int_req) begin
                        r_kind  <= KIND_INT;
                        r_code  <= int_code;
                        r_tval  <= '0;
                        r_epc   <= epc;
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (pipe_clear) begin
                        r_next_mcause <= {(r_kind == KIND_INT), 26'd0, r_code};
                        r_next_mepc   <= {r_epc[31:2], 2'b00};
                        r_next_mtval  <= r_tval;
                        if (r_kind == KIND_RET) begin
                            r_inj_trap    <= 1'b0;
                            r_inj_mstatus <= 1'b1;
                            r_next_mie    <= mstatus_mpie;
                            r_next_mpie   <= 1'b1;
                            r_next_mpp    <= HAS_U ? PRIV_U : PRIV_M;
                        end else begin
                            r_inj_trap    <= 1'b1;
                            r_inj_mstatus <= 1'b1;
                            r_next_mie    <= 1'b0;
                            r_next_mpie   <= mstatus_mie;
                            r_next_mpp    <= r_curr_priv;
                        end
                        r_state <= ST_COMMIT;
                    end
                end
                ST_COMMIT: begin
                    r_inj_trap    <= 1'b0;
                    r_inj_mstatus <= 1'b0;
                    r_insert_pc   <= 1'b1;
                    if (r_kind == KIND_RET) begin
                        r_priv_pc   <= mepc_in;
                        r_curr_priv <= mstatus_mpp;
                    end else begin
                        r_priv_pc   <= trap_target(mtvec_base, mtvec_mode,
                                                   (r_kind == KIND_INT), r_code);
                        r_curr_priv <= PRIV_M;
                    end
                    r_state <= ST_REDIRECT;
                end
                ST_REDIRECT: begin
                    r_insert_pc <= 1'b0;
                    r_state     <= ST_IDLE;
                end
                default: begin
                    r_inj_trap    <= 1'b0;
                    r_inj_mstatus <= 1'b0;
                    r_insert_pc   <= 1'b0;
                    r_state       <= ST_IDLE;
                end
            endcase
        end
    end

    assign inject_mcause  = r_inj_trap;
    assign inject_mepc    = r_inj_trap;
    assign inject_mtval   = r_inj_trap;
    assign inject_mstatus = r_inj_mstatus;
    assign next_mcause    = r_next_mcause;
    assign next_mepc      = r_next_mepc;
    assign next_mtval     = r_next_mtval;
    assign next_mie       = r_next_mie;
    assign next_mpie      = r_next_mpie;
    assign next_mpp       = r_next_mpp;
    assign insert_pc      = r_insert_pc;
    assign priv_pc        = r_priv_pc;
    assign curr_priv      = r_curr_priv;
    assign busy           = (r_state != ST_IDLE);
    assign hang_err       = w_hang;

endmodule

// File: tb/tb_priv_1_12_trap_seq.sv
// Self-checking bench for priv_1_12_trap_seq: directed scenarios plus
// randomized transactions compared against a transaction-level model.
module tb_priv_1_12_trap_seq;

    localparam int TO_W    = 8;
    localparam int TO_LIM  = (1 << TO_W) - 1;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        exc_req = 1'b0;
    logic [4:0]  exc_code = '0;
    logic [31:0] exc_tval = '0;
    logic        int_req = 1'b0;
    logic [4:0]  int_code = '0;
    logic        mret_req = 1'b0;
    logic [31:0] epc = '0;
    logic        pipe_clear = 1'b0;
    logic [29:0] mtvec_base = '0;
    logic [1:0]  mtvec_mode = '0;
    logic [31:0] mepc_in = '0;
    logic        mstatus_mie = 1'b0;
    logic        mstatus_mpie = 1'b0;
    logic [1:0]  mstatus_mpp = '0;

    logic        inject_mcause, inject_mepc, inject_mtval, inject_mstatus;
    logic [31:0] next_mcause, next_mepc, next_mtval;
    logic        next_mie, next_mpie;
    logic [1:0]  next_mpp;
    logic        insert_pc;
    logic [31:0] priv_pc;
    logic [1:0]  curr_priv;
    logic        busy, hang_err;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state and per-transaction expectations
    logic [1:0]  model_priv = 2'b11;
    bit          model_hang = 1'b0;
    logic [3:0]  e_inj;
    logic [31:0] e_mcause, e_mepc, e_mtval, e_pc;
    logic        e_mie, e_mpie;
    logic [1:0]  e_mpp, e_priv;

    always #5 CLK = ~CLK;

    priv_1_12_trap_seq #(.TIMEOUT_W(TO_W), .HAS_U(1'b1)) dut (
        .CLK(CLK), .RST(RST),
        .exc_req(exc_req), .exc_code(exc_code), .exc_tval(exc_tval),
        .int_req(int_req), .int_code(int_code), .mret_req(mret_req),
        .epc(epc), .pipe_clear(pipe_clear),
        .mtvec_base(mtvec_base), .mtvec_mode(mtvec_mode), .mepc_in(mepc_in),
        .mstatus_mie(mstatus_mie), .mstatus_mpie(mstatus_mpie), .mstatus_mpp(mstatus_mpp),
        .inject_mcause(inject_mcause), .inject_mepc(inject_mepc),
        .inject_mtval(inject_mtval), .inject_mstatus(inject_mstatus),
        .next_mcause(next_mcause), .next_mepc(next_mepc), .next_mtval(next_mtval),
        .next_mie(next_mie), .next_mpie(next_mpie), .next_mpp(next_mpp),
        .insert_pc(insert_pc), .priv_pc(priv_pc), .curr_priv(curr_priv),
        .busy(busy), .hang_err(hang_err)
    );

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_strobes"},
            {27'd0, inject_mcause, inject_mepc, inject_mtval, inject_mstatus, insert_pc}, 32'd0);
    endtask

    // Architectural outcome of the request currently presented on the inputs
    task automatic model_take();
        logic [31:0] base;
        bit          is_int;
        base = {mtvec_base, 2'b00};
        if (exc_req || (!mret_req && int_req)) begin
            is_int   = !exc_req;
            e_inj    = 4'b1111;
            e_mcause = is_int ? (32'h8000_0000 | 32'(int_code)) : 32'(exc_code);
            e_mepc   = epc & 32'hFFFF_FFFC;
            e_mtval  = is_int ? 32'd0 : exc_tval;
            e_mie    = 1'b0;
            e_mpie   = mstatus_mie;
            e_mpp    = model_priv;
            e_priv   = 2'b11;
            e_pc     = (is_int && mtvec_mode == 2'b01) ? base + 32'(4 * int_code) : base;
        end else begin
            e_inj    = 4'b0001;
            e_mcause = 32'd0;
            e_mepc   = 32'd0;
            e_mtval  = 32'd0;
            e_mie    = mstatus_mpie;
            e_mpie   = 1'b1;
            e_mpp    = 2'b00;
            e_priv   = mstatus_mpp;
            e_pc     = mepc_in;
        end
    endtask

    // One full transaction from the IDLE request cycle to the following IDLE cycle
    task automatic run_txn(input string tag, input int d, input bit hold_int, input bit noise);
        logic [31:0] pc_hold;
        chk({tag, "_idle_busy"}, busy, 0);
        model_take();
        pipe_clear = (d == 0);
        step();
        exc_req  = 1'b0;
        mret_req = 1'b0;
        if (!hold_int) int_req = 1'b0;
        chk({tag, "_drain_busy"}, busy, 1);
        chk_quiet({tag, "_drain"});
        for (int i = 0; i < d; i++) begin
            if (noise) begin
                exc_req  = 1'($urandom_range(0, 1));
                mret_req = 1'($urandom_range(0, 1));
                exc_code = 5'($urandom);
                exc_tval = $urandom;
                epc      = $urandom;
            end
            step();
            chk({tag, "_drain_hold"}, busy, 1);
            chk_quiet({tag, "_drain_hold"});
            chk({tag, "_hang"}, hang_err, (model_hang || (i + 1 >= TO_LIM)) ? 1 : 0);
        end
        exc_req  = 1'b0;
        mret_req = 1'b0;
        pipe_clear = 1'b1;
        step();
        if (d + 1 >= TO_LIM) model_hang = 1'b1;
        chk({tag, "_commit_inj"},
            {28'd0, inject_mcause, inject_mepc, inject_mtval, inject_mstatus}, 32'(e_inj));
        chk({tag, "_commit_insert"}, insert_pc, 0);
        if (e_inj[3]) begin
            chk({tag, "_mcause"}, next_mcause, e_mcause);
            chk({tag, "_mepc"}, next_mepc, e_mepc);
            chk({tag, "_mtval"}, next_mtval, e_mtval);
        end
        chk({tag, "_mstatus"}, {28'd0, next_mie, next_mpie, next_mpp}, {28'd0, e_mie, e_mpie, e_mpp});
        chk({tag, "_commit_hang"}, hang_err, model_hang);
        step();
        chk({tag, "_redir_insert"}, insert_pc, 1);
        chk({tag, "_redir_pc"}, priv_pc, e_pc);
        chk({tag, "_redir_priv"}, curr_priv, e_priv);
        chk({tag, "_redir_inj"},
            {28'd0, inject_mcause, inject_mepc, inject_mtval, inject_mstatus}, 0);
        model_priv = e_priv;
        pc_hold = e_pc;
        step();
        chk({tag, "_ret_busy"}, busy, 0);
        chk_quiet({tag, "_ret"});
        chk({tag, "_ret_pc"}, priv_pc, pc_hold);
    endtask

    initial begin
        // Reset state
        RST = 1'b1;
        step();
        step();
        chk("rst_busy", busy, 0);
        chk("rst_priv", curr_priv, 2'b11);
        chk("rst_pc", priv_pc, 0);
        chk("rst_hang", hang_err, 0);
        chk_quiet("rst");
        RST = 1'b0;
        step();

        // Illegal instruction, direct vector at 0x100
        mtvec_base = 30'h40; mtvec_mode = 2'b00;
        mstatus_mie = 1'b1; mstatus_mpie = 1'b0; mstatus_mpp = 2'b11;
        exc_req = 1'b1; exc_code = 5'd2; epc = 32'h0000_1006; exc_tval = 32'hDEAD_BEEF;
        run_txn("illegal", 0, 1'b0, 1'b0);

        // Vectored machine timer interrupt
        mtvec_base = 30'h80; mtvec_mode = 2'b01;
        int_req = 1'b1; int_code = 5'd7; epc = 32'h0000_2000;
        run_txn("mtimer", 0, 1'b0, 1'b0);

        // MRET back to U-mode
        mstatus_mie = 1'b0; mstatus_mpie = 1'b1; mstatus_mpp = 2'b00;
        mepc_in = 32'h0000_4000;
        mret_req = 1'b1;
        run_txn("mret", 0, 1'b0, 1'b0);

        // Simultaneous requests: exception wins, held interrupt follows 4 cycles later
        mstatus_mie = 1'b1;
        exc_req = 1'b1; mret_req = 1'b1; int_req = 1'b1;
        exc_code = 5'd5; int_code = 5'd11; epc = 32'h0000_3008; exc_tval = 32'h1234_5678;
        run_txn("prio_exc", 0, 1'b1, 1'b0);
        run_txn("prio_int", 0, 1'b0, 1'b0);

        // Drain hang: watchdog trips after 255 DRAIN cycles, then completes
        exc_req = 1'b1; exc_code = 5'd1; epc = 32'h0000_0040; exc_tval = 32'h0;
        run_txn("hang", 299, 1'b0, 1'b0);
        chk("hang_sticky", hang_err, 1);

        // Reset during DRAIN
        exc_req = 1'b1; pipe_clear = 1'b0;
        step();
        exc_req = 1'b0;
        chk("rstd_pre_busy", busy, 1);
        RST = 1'b1;
        step();
        RST = 1'b0;
        model_priv = 2'b11;
        model_hang = 1'b0;
        chk("rstd_busy", busy, 0);
        chk("rstd_priv", curr_priv, 2'b11);
        chk("rstd_hang", hang_err, 0);
        chk_quiet("rstd");
        step();
        chk("rstd_after_busy", busy, 0);
        chk_quiet("rstd_after");

        // Drop to U-mode, then reset during COMMIT of the next trap
        mstatus_mpie = 1'b1; mstatus_mpp = 2'b00; mepc_in = 32'h0000_8000;
        mret_req = 1'b1;
        run_txn("mret2", 1, 1'b0, 1'b0);
        exc_req = 1'b1; exc_code = 5'd8; epc = 32'h0000_8004; pipe_clear = 1'b1;
        step();
        exc_req = 1'b0;
        step();
        chk("rstc_pre_inj", inject_mstatus, 1);
        RST = 1'b1;
        step();
        RST = 1'b0;
        model_priv = 2'b11;
        chk("rstc_busy", busy, 0);
        chk("rstc_priv", curr_priv, 2'b11);
        chk("rstc_pc", priv_pc, 0);
        chk_quiet("rstc");
        step();
        chk_quiet("rstc_after");
        chk("rstc_after_busy", busy, 0);

        // Randomized transactions against the model
        for (int t = 0; t < 60; t++) begin
            logic [2:0] r;
            r = 3'($urandom_range(1, 7));
            mtvec_base   = $urandom;
            mtvec_mode   = 2'($urandom);
            mepc_in      = $urandom;
            mstatus_mie  = 1'($urandom);
            mstatus_mpie = 1'($urandom);
            mstatus_mpp  = 2'($urandom);
            exc_code     = 5'($urandom);
            int_code     = 5'($urandom);
            exc_tval     = $urandom;
            epc          = $urandom;
            exc_req  = r[0];
            int_req  = r[1];
            mret_req = r[2];
            run_txn("rand", int'($urandom_range(0, 4)), 1'b0, 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
